// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature step decoder: AB encodings,
// FSM state type and the transition classification functions.
package qdec_pkg;

    typedef logic [1:0] ab_t;

    // AB encodings listed in up-count order: 00 -> 10 -> 11 -> 01 -> 00
    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_10 = 2'b10;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_01 = 2'b01;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } qdec_state_t;

    // 1 when prev -> cur is one Gray step in the up direction
    function automatic logic step_dir(input ab_t prev, input ab_t cur);
        logic up;
        case (prev)
            AB_00:   up = (cur == AB_10);
            AB_10:   up = (cur == AB_11);
            AB_11:   up = (cur == AB_01);
            default: up = (cur == AB_00);
        endcase
        return up;
    endfunction

    function automatic logic is_single_step(input ab_t prev, input ab_t cur);
        return ^(prev ^ cur);
    endfunction

    function automatic logic is_jump(input ab_t prev, input ab_t cur);
        return &(prev ^ cur);
    endfunction

endpackage

// File: rtl/qdec_input_sync.sv
// Two-flop synchronizer for one asynchronous encoder input. With
// QDEC_GLITCH_FILTER_EN defined, a FILT-deep stability filter follows it.
module qdec_input_sync #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic level_c
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned HIST_W = FILT - 1;

    logic [HIST_W-1:0] hist_q, hist_d;
    logic              level_q, level_d;
    logic              stable_c;

    // Accept the synchronized level once it and the previous FILT-1 samples agree
    always_comb begin
        stable_c = (hist_q == {HIST_W{s2_q}});
        level_c  = stable_c ? s2_q : level_q;
        level_d  = level_c;
        hist_d   = HIST_W'({hist_q, s2_q});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            level_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end
`else
    // FILT has no effect without the filter
    logic unused_filt;

    always_comb begin
        level_c     = s2_q;
        unused_filt = ^FILT;
    end
`endif

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder front end driving an up/down counter's enable/up_down/load/data_in.
// Optional input glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quadrature_step_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned FILT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         ch_a,
    input  logic         ch_b,
    input  logic         index,
    input  logic         index_load_en,
    input  logic [N-1:0] home_value,
    input  logic         err_clr,
    output logic         cnt_enable,
    output logic         cnt_up_down,
    output logic         cnt_load,
    output logic [N-1:0] cnt_data,
    output logic         dir,
    output logic         err,
    output logic         err_sticky
);

    logic a_c, b_c, idx_c;
    ab_t  cur_c;

    qdec_input_sync #(.FILT(FILT)) u_sync_a (
        .clk     (clk),
        .reset   (reset),
        .d_in    (ch_a),
        .level_c (a_c)
    );

    qdec_input_sync #(.FILT(FILT)) u_sync_b (
        .clk     (clk),
        .reset   (reset),
        .d_in    (ch_b),
        .level_c (b_c)
    );

    qdec_input_sync #(.FILT(FILT)) u_sync_idx (
        .clk     (clk),
        .reset   (reset),
        .d_in    (index),
        .level_c (idx_c)
    );

    qdec_state_t  state_q, state_d;
    ab_t          prev_q, prev_d;
    logic         idx_prev_q, idx_prev_d;
    logic         cnt_enable_q, cnt_enable_d;
    logic         cnt_up_down_q, cnt_up_down_d;
    logic         cnt_load_q, cnt_load_d;
    logic [N-1:0] cnt_data_q, cnt_data_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;
    logic         err_sticky_q, err_sticky_d;

    logic idx_rise_c, single_c, jump_c, load_c, step_c;

    // Decode: INIT only seeds prev; TRACK classifies prev -> cur each cycle
    always_comb begin
        cur_c      = {a_c, b_c};
        state_d    = ST_TRACK;
        prev_d     = cur_c;
        idx_prev_d = idx_c;

        idx_rise_c = idx_c & ~idx_prev_q;
        single_c   = (state_q == ST_TRACK) && is_single_step(prev_q, cur_c);
        jump_c     = (state_q == ST_TRACK) && is_jump(prev_q, cur_c);

        // A load in the same cycle as a step discards the step
        load_c     = enable && index_load_en && idx_rise_c;
        step_c     = enable && single_c && !load_c;

        cnt_enable_d  = step_c;
        cnt_load_d    = load_c;
        err_d         = enable && jump_c;
        dir_d         = step_c ? step_dir(prev_q, cur_c) : dir_q;
        cnt_up_down_d = dir_d;
        cnt_data_d    = load_c ? home_value : cnt_data_q;
        err_sticky_d  = err_d | (err_sticky_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            prev_q        <= AB_00;
            idx_prev_q    <= 1'b0;
            cnt_enable_q  <= 1'b0;
            cnt_up_down_q <= 1'b0;
            cnt_load_q    <= 1'b0;
            cnt_data_q    <= '0;
            dir_q         <= 1'b0;
            err_q         <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            idx_prev_q    <= idx_prev_d;
            cnt_enable_q  <= cnt_enable_d;
            cnt_up_down_q <= cnt_up_down_d;
            cnt_load_q    <= cnt_load_d;
            cnt_data_q    <= cnt_data_d;
            dir_q         <= dir_d;
            err_q         <= err_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign cnt_enable  = cnt_enable_q;
    assign cnt_up_down = cnt_up_down_q;
    assign cnt_load    = cnt_load_q;
    assign cnt_data    = cnt_data_q;
    assign dir         = dir_q;
    assign err         = err_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Self-checking bench for quadrature_step_decoder: directed scenarios plus a
// randomized encoder walk scored against a position-arithmetic reference model.
`timescale 1ns/1ps
module tb_quadrature_step_decoder;

    localparam int unsigned N    = 4;
    localparam int unsigned FILT = 3;
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int LAT      = 3 + int'(FILT) - 1;
    localparam int MIN_HOLD = int'(FILT);
`else
    localparam int LAT      = 3;
    localparam int MIN_HOLD = 1;
`endif

    logic         clk = 1'b0;
    logic         reset, enable, ch_a, ch_b, index, index_load_en, err_clr;
    logic [N-1:0] home_value;
    logic         cnt_enable, cnt_up_down, cnt_load, dir, err, err_sticky;
    logic [N-1:0] cnt_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Totals seen on the outputs plus the downstream counter they would drive
    int           mon_up   = 0;
    int           mon_dn   = 0;
    int           mon_err  = 0;
    int           mon_load = 0;
    logic [N-1:0] mon_cnt  = '0;

    logic [1:0] cur_ab = 2'b00;
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    typedef struct {
        int           en_k;
        int           n_en;
        logic         ud;
        int           err_k;
        int           n_err;
        logic         sticky_err;
        int           load_k;
        int           n_load;
        logic [N-1:0] data;
    } obs_t;

    quadrature_step_decoder #(.N(N), .FILT(FILT)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ch_a          (ch_a),
        .ch_b          (ch_b),
        .index         (index),
        .index_load_en (index_load_en),
        .home_value    (home_value),
        .err_clr       (err_clr),
        .cnt_enable    (cnt_enable),
        .cnt_up_down   (cnt_up_down),
        .cnt_load      (cnt_load),
        .cnt_data      (cnt_data),
        .dir           (dir),
        .err           (err),
        .err_sticky    (err_sticky)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (cnt_enable === 1'b1) begin
                if (cnt_up_down === 1'b1) mon_up++;
                else mon_dn++;
            end
            if (err === 1'b1) mon_err++;
            if (cnt_load === 1'b1) begin
                mon_load++;
                mon_cnt = cnt_data;
            end else if (cnt_enable === 1'b1) begin
                mon_cnt = (cnt_up_down === 1'b1) ? N'(mon_cnt + 1'b1) : N'(mon_cnt - 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    function automatic int ab_pos(input logic [1:0] v);
        for (int p = 0; p < 4; p++) begin
            if (seq[p] == v) return p;
        end
        return 0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_up   = 0;
        mon_dn   = 0;
        mon_err  = 0;
        mon_load = 0;
    endtask

    // Drive AB and observe outputs for `hold` cycles
    task automatic drive_hold(input logic [1:0] v, input int hold, output obs_t o);
        {ch_a, ch_b} = v;
        cur_ab       = v;
        o = '{en_k: 0, n_en: 0, ud: 1'b0, err_k: 0, n_err: 0, sticky_err: 1'b0,
              load_k: 0, n_load: 0, data: '0};
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (cnt_enable === 1'b1) begin
                o.n_en++;
                if (o.en_k == 0) begin
                    o.en_k = k;
                    o.ud   = cnt_up_down;
                end
            end
            if (err === 1'b1) begin
                o.n_err++;
                if (o.err_k == 0) begin
                    o.err_k      = k;
                    o.sticky_err = err_sticky;
                end
            end
            if (cnt_load === 1'b1) begin
                o.n_load++;
                if (o.load_k == 0) begin
                    o.load_k = k;
                    o.data   = cnt_data;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; ch_a = 1'b0; ch_b = 1'b0; index = 1'b0;
        index_load_en = 1'b0; err_clr = 1'b0; home_value = '0; cur_ab = 2'b00;
        repeat (3) tick();
        n_checks++;
        if ({cnt_enable, cnt_up_down, cnt_load, dir, err, err_sticky} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {cnt_enable, cnt_up_down, cnt_load, dir, err, err_sticky});
        end
        n_checks++;
        if (cnt_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", cnt_data);
        end
        reset = 1'b0;
        repeat (LAT + 3) tick();
        n_checks++;
        if (mon_up + mon_dn + mon_err + mon_load != 0) begin
            n_fail++;
            $display("FAIL reset_release: pulses up=%0d dn=%0d err=%0d load=%0d expected none",
                     mon_up, mon_dn, mon_err, mon_load);
        end
    endtask

    task automatic test_up_sequence();
        obs_t o;
        clear_mon();
        mon_cnt = '0;
        for (int i = 1; i <= 4; i++) begin
            drive_hold(seq[i % 4], 5, o);
            n_checks++;
            if (o.en_k !== LAT || o.n_en !== 1 || o.ud !== 1'b1) begin
                n_fail++;
                $display("FAIL up_step%0d: latency=%0d pulses=%0d up_down=%b expected latency=%0d pulses=1 up_down=1",
                         i, o.en_k, o.n_en, o.ud, LAT);
            end
        end
        n_checks++;
        if (mon_up !== 4 || mon_dn !== 0 || dir !== 1'b1 || cnt_up_down !== 1'b1 || mon_cnt !== 4'h4) begin
            n_fail++;
            $display("FAIL up_total: up=%0d dn=%0d dir=%b ud=%b cnt=%h expected 4 0 1 1 4",
                     mon_up, mon_dn, dir, cnt_up_down, mon_cnt);
        end
    endtask

    task automatic test_down_sequence();
        obs_t o;
        clear_mon();
        mon_cnt = '0;
        for (int i = 3; i >= 1; i--) begin
            drive_hold(seq[i], 5, o);
            n_checks++;
            if (o.en_k !== LAT || o.n_en !== 1 || o.ud !== 1'b0) begin
                n_fail++;
                $display("FAIL down_step%0d: latency=%0d pulses=%0d up_down=%b expected latency=%0d pulses=1 up_down=0",
                         i, o.en_k, o.n_en, o.ud, LAT);
            end
        end
        n_checks++;
        if (mon_dn !== 3 || mon_up !== 0 || dir !== 1'b0 || cnt_up_down !== 1'b0 || mon_cnt !== 4'hD) begin
            n_fail++;
            $display("FAIL down_total: dn=%0d up=%0d dir=%b ud=%b cnt=%h expected 3 0 0 0 d",
                     mon_dn, mon_up, dir, cnt_up_down, mon_cnt);
        end
    endtask

    task automatic test_error();
        obs_t o;
        drive_hold(2'b00, 5, o);
        clear_mon();
        drive_hold(2'b11, 6, o);
        n_checks++;
        if (o.err_k !== LAT || o.n_err !== 1 || o.n_en !== 0 || err_sticky !== 1'b1 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL err_jump: err_at=%0d errs=%0d steps=%0d sticky=%b dir=%b expected %0d 1 0 1 0",
                     o.err_k, o.n_err, o.n_en, err_sticky, dir, LAT);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: sticky=%b expected 0", err_sticky);
        end
        // Clear held across a new error: the set must win in that cycle
        err_clr = 1'b1;
        drive_hold(2'b00, 6, o);
        n_checks++;
        if (o.err_k !== LAT || o.sticky_err !== 1'b1 || err_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set_wins: err_at=%0d sticky_at_err=%b sticky_after=%b expected %0d 1 0",
                     o.err_k, o.sticky_err, err_sticky, LAT);
        end
        err_clr = 1'b0;
    endtask

    task automatic test_index();
        obs_t         o;
        logic [N-1:0] hv;
        index_load_en = 1'b1;
        hv = 4'h5;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) hv = N'($urandom_range(0, 15));
            home_value = hv;
            index = 1'b1;
            drive_hold(cur_ab, 6, o);
            n_checks++;
            if (o.load_k !== LAT || o.n_load !== 1 || o.data !== hv || o.n_en !== 0) begin
                n_fail++;
                $display("FAIL index_load%0d: load_at=%0d loads=%0d data=%h steps=%0d expected %0d 1 %h 0",
                         i, o.load_k, o.n_load, o.data, o.n_en, LAT, hv);
            end
            index = 1'b0;
            home_value = ~hv;
            drive_hold(cur_ab, 6, o);
            n_checks++;
            if (o.n_load !== 0 || cnt_data !== hv) begin
                n_fail++;
                $display("FAIL index_hold%0d: loads=%0d data=%h expected 0 %h", i, o.n_load, cnt_data, hv);
            end
        end
        index_load_en = 1'b0;
        index = 1'b1;
        drive_hold(cur_ab, 6, o);
        n_checks++;
        if (o.n_load !== 0 || cnt_data !== hv) begin
            n_fail++;
            $display("FAIL index_load_en_off: loads=%0d data=%h expected 0 %h", o.n_load, cnt_data, hv);
        end
        index = 1'b0;
        drive_hold(cur_ab, 6, o);
    endtask

    task automatic test_load_vs_step();
        obs_t o;
        index_load_en = 1'b1;
        home_value = 4'hA;
        index = 1'b1;
        drive_hold(2'b10, 6, o);
        n_checks++;
        if (o.load_k !== LAT || o.n_en !== 0 || o.data !== 4'hA || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL load_vs_step: load_at=%0d steps=%0d data=%h dir=%b expected %0d 0 a 0",
                     o.load_k, o.n_en, o.data, dir, LAT);
        end
        index = 1'b0;
        drive_hold(2'b11, 6, o);
        n_checks++;
        if (o.en_k !== LAT || o.ud !== 1'b1 || o.n_load !== 0 || o.n_err !== 0) begin
            n_fail++;
            $display("FAIL after_discard: step_at=%0d ud=%b loads=%0d errs=%0d expected %0d 1 0 0",
                     o.en_k, o.ud, o.n_load, o.n_err, LAT);
        end
    endtask

    task automatic test_enable_gate();
        obs_t o;
        enable = 1'b0;
        clear_mon();
        home_value = 4'h3;
        index = 1'b1;
        drive_hold(2'b01, 5, o);
        drive_hold(2'b00, 5, o);
        enable = 1'b1;
        drive_hold(2'b00, 6, o);
        n_checks++;
        if (mon_up + mon_dn + mon_err + mon_load != 0 || cnt_data !== 4'hA || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_gate: up=%0d dn=%0d err=%0d load=%0d data=%h dir=%b expected no pulses data=a dir=1",
                     mon_up, mon_dn, mon_err, mon_load, cnt_data, dir);
        end
        index = 1'b0;
        drive_hold(2'b10, 6, o);
        n_checks++;
        if (o.en_k !== LAT || o.ud !== 1'b1 || o.n_load !== 0) begin
            n_fail++;
            $display("FAIL enable_tracked: step_at=%0d ud=%b loads=%0d expected %0d 1 0",
                     o.en_k, o.ud, o.n_load, LAT);
        end
    endtask

    task automatic test_glitch();
        obs_t       o;
        logic [1:0] orig, g;
        orig = cur_ab;
        g    = cur_ab ^ 2'b10;
        clear_mon();
        drive_hold(g, 1, o);
        drive_hold(orig, 8, o);
`ifdef QDEC_GLITCH_FILTER_EN
        n_checks++;
        if (mon_up + mon_dn + mon_err != 0) begin
            n_fail++;
            $display("FAIL glitch_filtered: up=%0d dn=%0d err=%0d expected 0 0 0", mon_up, mon_dn, mon_err);
        end
        drive_hold(g, 8, o);
        n_checks++;
        if (o.n_en !== 1 || o.en_k !== LAT) begin
            n_fail++;
            $display("FAIL filter_accept: pulses=%0d at=%0d expected 1 at %0d", o.n_en, o.en_k, LAT);
        end
`else
        n_checks++;
        if (mon_up !== 1 || mon_dn !== 1 || o.n_en !== 2 || mon_err !== 0) begin
            n_fail++;
            $display("FAIL max_rate: up=%0d dn=%0d pulses=%0d err=%0d expected 1 1 2 0",
                     mon_up, mon_dn, o.n_en, mon_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        obs_t o;
        {ch_a, ch_b} = seq[(ab_pos(cur_ab) + 1) % 4];
        repeat (LAT - 1) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({cnt_enable, cnt_up_down, cnt_load, dir, err, err_sticky} !== 6'b0 || cnt_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: flags=%b data=%h expected 000000 0",
                     {cnt_enable, cnt_up_down, cnt_load, dir, err, err_sticky}, cnt_data);
        end
        {ch_a, ch_b} = 2'b00;
        cur_ab = 2'b00;
        repeat (2) tick();
        reset = 1'b0;
        clear_mon();
        drive_hold(2'b00, 8, o);
        n_checks++;
        if (o.n_en !== 0 || o.n_err !== 0 || o.n_load !== 0) begin
            n_fail++;
            $display("FAIL reset_exit: steps=%0d errs=%0d loads=%0d expected 0 0 0", o.n_en, o.n_err, o.n_load);
        end
        drive_hold(2'b10, 6, o);
        n_checks++;
        if (o.en_k !== LAT || o.ud !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_resume: step_at=%0d ud=%b expected %0d 1", o.en_k, o.ud, LAT);
        end
    endtask

    task automatic test_random();
        obs_t         o;
        int           m_up, m_dn, m_err, p, np, d, moves;
        logic [N-1:0] m_cnt;
        logic         m_dir, m_sticky;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        index = 1'b0;
        index_load_en = 1'b0;
        clear_mon();
        mon_cnt = '0;
        m_up = 0; m_dn = 0; m_err = 0; m_cnt = '0; m_dir = 1'b1; m_sticky = 1'b0;
        for (int phase = 0; phase < 3; phase++) begin
            enable = (phase != 1);
            moves  = (phase == 1) ? 20 : 40;
            for (int mv = 0; mv < moves; mv++) begin
                int r;
                r = int'($urandom_range(0, 9));
                p = ab_pos(cur_ab);
                if (r < 4)       np = (p + 1) % 4;
                else if (r < 8)  np = (p + 3) % 4;
                else if (r == 8) np = (p + 2) % 4;
                else             np = p;
                d = (np - p + 4) % 4;
                if (enable) begin
                    if (d == 1) begin
                        m_up++; m_cnt = N'(m_cnt + 1'b1); m_dir = 1'b1;
                    end else if (d == 3) begin
                        m_dn++; m_cnt = N'(m_cnt - 1'b1); m_dir = 1'b0;
                    end else if (d == 2) begin
                        m_err++; m_sticky = 1'b1;
                    end
                end
                drive_hold(seq[np], int'($urandom_range(MIN_HOLD, MIN_HOLD + 3)), o);
            end
            drive_hold(cur_ab, LAT + 2, o);
        end
        n_checks++;
        if (mon_up !== m_up || mon_dn !== m_dn || mon_err !== m_err || mon_load !== 0) begin
            n_fail++;
            $display("FAIL random_counts: up=%0d dn=%0d err=%0d load=%0d expected %0d %0d %0d 0",
                     mon_up, mon_dn, mon_err, mon_load, m_up, m_dn, m_err);
        end
        n_checks++;
        if (mon_cnt !== m_cnt || dir !== m_dir || err_sticky !== m_sticky) begin
            n_fail++;
            $display("FAIL random_state: cnt=%h dir=%b sticky=%b expected %h %b %b",
                     mon_cnt, dir, err_sticky, m_cnt, m_dir, m_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_up_sequence();
        test_down_sequence();
        test_error();
        test_index();
        test_load_vs_step();
        test_enable_gate();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
